// File: rtl/table_sweep_pkg.sv
// table_sweep_pkg: shared state encoding and widths for the truth-table sweeper.
package table_sweep_pkg;

    localparam int NVEC  = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;
    localparam int ERR_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2,
        S_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/table_sweep_settle_timer.sv
// settle_timer: counts cycles while enabled, flags terminal count at SETTLE-1.
// Clear reloads zero, so each vector starts its settle window from scratch.
import table_sweep_pkg::*;

module settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    // Cycle counter: clear has priority over count enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_tc = (r_cnt == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/table_sweep.sv
// table_sweep: drives abc through 000..111, samples s_in after a settle window,
// builds an 8-bit truth table and counts mismatches against EXPECTED.
// Optional macro TABLE_SWEEP_STOP_ON_ERR_EN: abort the sweep on the first mismatch.
import table_sweep_pkg::*;

module table_sweep #(
    parameter logic [NVEC-1:0] EXPECTED = 8'hF4,
    parameter int              SETTLE   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             s_in,
    output logic [IDX_W-1:0] abc,
    output logic             busy,
    output logic             done,
    output logic [NVEC-1:0]  table_out,
    output logic [ERR_W-1:0] err_count,
    output logic             pass
);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic [NVEC-1:0]  r_table;
    logic [ERR_W-1:0] r_err;
    logic             r_pass;
    logic             w_tmr_clr;
    logic             w_tmr_en;
    logic             w_tc;
    logic             w_mis;
    logic             w_stop;

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_tmr_clr),
        .i_en  (w_tmr_en),
        .o_tc  (w_tc)
    );

    assign w_mis = (s_in != EXPECTED[r_idx]);

`ifdef TABLE_SWEEP_STOP_ON_ERR_EN
    assign w_stop = w_mis;
`else
    assign w_stop = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and settle-timer control.
    always_comb begin
        w_next    = r_state;
        w_tmr_clr = 1'b0;
        w_tmr_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next    = S_WAIT;
                    w_tmr_clr = 1'b1;
                end
            end
            S_WAIT: begin
                w_tmr_en = 1'b1;
                if (w_tc)
                    w_next = S_CAPT;
            end
            S_CAPT: begin
                w_tmr_clr = 1'b1;
                if (r_idx == IDX_W'(NVEC - 1) || w_stop)
                    w_next = S_FIN;
                else
                    w_next = S_WAIT;
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: vector index, captured table, error count and pass flag.
    // abc is the index register itself, so it holds the last vector in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_table <= '0;
            r_err   <= '0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_table <= '0;
                        r_err   <= '0;
                        r_pass  <= 1'b0;
                    end
                end
                S_CAPT: begin
                    r_table[r_idx] <= s_in;
                    if (w_mis)
                        r_err <= r_err + ERR_W'(1);
                    if (w_next == S_WAIT)
                        r_idx <= r_idx + IDX_W'(1);
                end
                S_FIN:   r_pass <= (r_err == '0);
                default: ;
            endcase
        end
    end

    assign abc       = r_idx;
    assign busy      = (r_state == S_WAIT) || (r_state == S_CAPT);
    assign done      = (r_state == S_FIN);
    assign table_out = r_table;
    assign err_count = r_err;
    assign pass      = r_pass;

endmodule
